// File: rtl/card_dealer.sv
// card_dealer: deals blackjack ranks from a per-rank tracked deck, candidates from an 8-bit LFSR.
// Define CARD_DEALER_SEQ_EN to draw candidates from a wrapping rank pointer instead.

module card_dealer #(
    parameter int unsigned COPIES = 4,
    parameter logic [7:0]  SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       deal_req,
    input  logic       shuffle,
    output logic [5:0] card_idx,
    output logic [3:0] card_val,
    output logic       card_valid,
    output logic       deal_err,
    output logic       busy,
    output logic [5:0] cards_left,
    output logic       deck_empty
);

    localparam int unsigned NumRanks   = 13;
    localparam logic [3:0]  LastRank   = 4'd12;
    localparam logic [5:0]  NoCard     = 6'd63;
    localparam logic [5:0]  FullDeck   = 6'(NumRanks * COPIES);
    localparam logic [2:0]  RankCopies = 3'(COPIES);

    typedef enum logic {StIdle, StDraw} state_e;

    state_e      state_q;
    logic [2:0]  cnt_q [NumRanks];
    logic [3:0]  rej_q;
    logic [5:0]  card_idx_q;
    logic [3:0]  card_val_q;
    logic        card_valid_q;
    logic        deal_err_q;
    logic [5:0]  cards_left_q;

    logic [12:0] avail;
    logic [3:0]  cand;
    logic [3:0]  low_rank;
    logic [3:0]  sel_rank;
    logic        cand_hit;
    logic        draw_active;
    logic        take;

    function automatic logic [3:0] rank_points(input logic [3:0] r);
        if (r == 4'd0) begin
            return 4'd1;
        end else if (r <= 4'd8) begin
            return r + 4'd1;
        end else begin
            return 4'd10;
        end
    endfunction

`ifdef CARD_DEALER_SEQ_EN
    logic [3:0] ptr_q;

    function automatic logic [3:0] next_rank(input logic [3:0] r);
        return (r >= LastRank) ? 4'd0 : r + 4'd1;
    endfunction

    assign cand = ptr_q;

    // After a deal the pointer resumes just past the dealt rank, fallback included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 4'd0;
        end else if (take) begin
            ptr_q <= next_rank(sel_rank);
        end else if (draw_active) begin
            ptr_q <= next_rank(ptr_q);
        end
    end
`else
    logic [7:0] lfsr_q;

    assign cand = lfsr_q[3:0];

    // Galois form, mask 8'hB8; free-running so the draw sequence depends on request timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else if (lfsr_q[0]) begin
            lfsr_q <= {1'b0, lfsr_q[7:1]} ^ 8'hB8;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[7:1]};
        end
    end
`endif

    always_comb begin
        avail    = '0;
        low_rank = 4'd0;
        // Scan downward so the last match left standing is the lowest rank still in the deck.
        for (int i = 12; i >= 0; i--) begin
            avail[i] = (cnt_q[i] != 3'd0);
            if (avail[i]) begin
                low_rank = 4'(i);
            end
        end
        cand_hit    = (cand <= LastRank) && avail[cand];
        sel_rank    = cand_hit ? cand : low_rank;
        draw_active = (state_q == StDraw) && !shuffle;
        take        = draw_active && (cand_hit || (rej_q == 4'hF));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            rej_q        <= 4'd0;
            card_idx_q   <= NoCard;
            card_val_q   <= 4'd0;
            card_valid_q <= 1'b0;
            deal_err_q   <= 1'b0;
            cards_left_q <= FullDeck;
            for (int i = 0; i < 13; i++) begin
                cnt_q[i] <= RankCopies;
            end
        end else begin
            card_valid_q <= 1'b0;
            deal_err_q   <= 1'b0;
            if (shuffle) begin
                state_q      <= StIdle;
                card_idx_q   <= NoCard;
                card_val_q   <= 4'd0;
                cards_left_q <= FullDeck;
                for (int i = 0; i < 13; i++) begin
                    cnt_q[i] <= RankCopies;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (deal_req) begin
                            if (cards_left_q == 6'd0) begin
                                deal_err_q <= 1'b1;
                            end else begin
                                state_q <= StDraw;
                                rej_q   <= 4'd0;
                            end
                        end
                    end
                    StDraw: begin
                        if (take) begin
                            card_idx_q      <= {2'b00, sel_rank};
                            card_val_q      <= rank_points(sel_rank);
                            cnt_q[sel_rank] <= cnt_q[sel_rank] - 3'd1;
                            cards_left_q    <= cards_left_q - 6'd1;
                            card_valid_q    <= 1'b1;
                            state_q         <= StIdle;
                        end else begin
                            rej_q <= rej_q + 4'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign card_idx   = card_idx_q;
    assign card_val   = card_val_q;
    assign card_valid = card_valid_q;
    assign deal_err   = deal_err_q;
    assign busy       = (state_q == StDraw);
    assign cards_left = cards_left_q;
    assign deck_empty = (cards_left_q == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// Randomised bench for card_dealer: a deck-level reference model predicts every dealt card,
// its draw latency, the error pulse and the shuffle/reset behaviour.

module tb_card_dealer;

    localparam int         COPIES = 4;
    localparam logic [7:0] SEED   = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic       deal_req;
    logic       shuffle;
    logic [5:0] card_idx;
    logic [3:0] card_val;
    logic       card_valid;
    logic       deal_err;
    logic       busy;
    logic [5:0] cards_left;
    logic       deck_empty;

    card_dealer #(
        .COPIES(COPIES),
        .SEED  (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .deal_req  (deal_req),
        .shuffle   (shuffle),
        .card_idx  (card_idx),
        .card_val  (card_val),
        .card_valid(card_valid),
        .deal_err  (deal_err),
        .busy      (busy),
        .cards_left(cards_left),
        .deck_empty(deck_empty)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cnt[13];
    int tally[13];
    int left;
    int m_idx;

`ifdef CARD_DEALER_SEQ_EN
    int m_ptr = 0;
`else
    logic [7:0] m_lfsr;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rank_val(input int r);
        if (r == 0) return 1;
        if (r <= 8) return r + 1;
        return 10;
    endfunction

    task automatic restore_model();
        for (int i = 0; i < 13; i++) cnt[i] = COPIES;
        left  = 13 * COPIES;
        m_idx = 63;
    endtask

    // Walk the candidate stream for up to 16 draw cycles; the 16th falls back to lowest rank left.
    task automatic predict(output int k, output int rank);
        int c;
`ifdef CARD_DEALER_SEQ_EN
        int p = m_ptr;
`else
        logic [7:0] l = m_lfsr;
`endif
        rank = -1;
        k    = 0;
        for (int i = 1; i <= 16 && rank < 0; i++) begin
`ifdef CARD_DEALER_SEQ_EN
            c = p;
`else
            c = int'(l & 8'h0F);
`endif
            k = i;
            if (c <= 12 && cnt[c] > 0) begin
                rank = c;
            end else if (i == 16) begin
                for (int r = 12; r >= 0; r--) if (cnt[r] > 0) rank = r;
            end else begin
`ifdef CARD_DEALER_SEQ_EN
                p = (p == 12) ? 0 : p + 1;
`else
                l = lfsr_step(l);
`endif
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_idx"}, card_idx, 63);
        check({tag, "_val"}, card_val, 0);
        check({tag, "_valid"}, card_valid, 0);
        check({tag, "_err"}, deal_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_left"}, cards_left, 13 * COPIES);
        check({tag, "_empty"}, deck_empty, 0);
    endtask

    // Request one card; pulses deal_req randomly while busy to show it is not queued.
    task automatic deal_one();
        int  k;
        int  rank;
        int  n;
        bit  got;
        deal_req = 1'b1;
        @(posedge clk);
        #1 deal_req = 1'b0;
        if (left == 0) begin
            check("err_pulse", deal_err, 1);
            check("err_busy", busy, 0);
            check("err_valid", card_valid, 0);
            @(posedge clk);
            #1;
            check("err_clear", deal_err, 0);
            check("err_idx_hold", card_idx, m_idx);
            check("err_no_valid", card_valid, 0);
            return;
        end
        predict(k, rank);
        check("deal_noerr", deal_err, 0);
        check("busy_rise", busy, 1);
        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            deal_req = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 deal_req = 1'b0;
            n++;
            if (card_valid) got = 1'b1;
        end
        check("valid_seen", got, 1);
        if (!got) return;
        check("latency", n, k);
        check("card_idx", card_idx, rank);
        check("card_val", card_val, rank_val(rank));
        if (card_idx < 13) tally[card_idx]++;
        cnt[rank]--;
        left--;
        m_idx = rank;
`ifdef CARD_DEALER_SEQ_EN
        m_ptr = (rank == 12) ? 0 : rank + 1;
`endif
        check("cards_left", cards_left, left);
        check("deck_empty", deck_empty, (left == 0) ? 1 : 0);
        check("busy_fall", busy, 0);
    endtask

    initial begin
        reset    = 1'b1;
        deal_req = 1'b0;
        shuffle  = 1'b0;
        restore_model();
        for (int i = 0; i < 13; i++) tally[i] = 0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            deal_one();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Shuffle and deal_req together from IDLE: shuffle wins, no draw starts.
        deal_req = 1'b1;
        shuffle  = 1'b1;
        @(posedge clk);
        #1 deal_req = 1'b0;
        shuffle = 1'b0;
        restore_model();
        check("same_busy", busy, 0);
        check("same_err", deal_err, 0);
        check("same_left", cards_left, left);
        check("same_idx", card_idx, 63);
        check("same_val", card_val, 0);
        @(posedge clk);
        #1;
        check("same_no_valid", card_valid, 0);
        check("same_busy2", busy, 0);

        // Shuffle in the cycle after the request aborts the draw.
        deal_one();
        deal_one();
        deal_req = 1'b1;
        @(posedge clk);
        #1 deal_req = 1'b0;
        shuffle = 1'b1;
        @(posedge clk);
        #1 shuffle = 1'b0;
        restore_model();
        check("abort_valid", card_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_left", cards_left, left);
        check("abort_idx", card_idx, 63);
        check("abort_val", card_val, 0);
        @(posedge clk);
        #1;
        check("abort_valid2", card_valid, 0);

        // Drain the full deck, then one request too many.
        for (int i = 0; i < 13; i++) tally[i] = 0;
        while (left > 0) deal_one();
        for (int r = 0; r < 13; r++) check($sformatf("tally_rank%0d", r), tally[r], COPIES);
        check("drained_empty", deck_empty, 1);
        check("drained_left", cards_left, 0);
        deal_one();

        // Asynchronous reset in the middle of a draw.
        @(negedge clk) shuffle = 1'b1;
        @(posedge clk);
        #1 shuffle = 1'b0;
        restore_model();
        deal_req = 1'b1;
        @(posedge clk);
        #1 deal_req = 1'b0;
        check("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async");
        @(negedge clk) reset = 1'b0;
        restore_model();
`ifdef CARD_DEALER_SEQ_EN
        m_ptr = 0;
`endif
        #1 check("post_reset_no_valid", card_valid, 0);
        for (int i = 0; i < 3; i++) deal_one();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
